// File: rtl/ethernet_frame_tx.sv
// Transmit-side Ethernet MAC framer.
// Builds preamble, SFD, header, payload, zero padding and FCS on a byte-wide
// stream, then holds off for the inter-frame gap before taking the next frame.
// The state register names the phase whose byte is being decided this cycle;
// that byte appears on the registered outputs one cycle later.
module ethernet_frame_tx #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_BYTES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ether_type,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_data_valid,
  output logic [7:0]  tx_data_out,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_trunc
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DEST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    idx_reg, idx_next;
  logic [10:0]   pay_cnt_reg, pay_cnt_next;
  logic [10:0]   pay_cnt_inc;
  logic [111:0]  hdr_reg, hdr_next;
  logic [31:0]   crc_reg, crc_next;
  logic          crc_en, crc_init;
  logic          in_ready_reg, in_ready_next;
  logic          tx_valid_reg, tx_valid_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_busy_reg, tx_busy_next;
  logic          tx_done_reg, tx_done_next;
  logic          tx_trunc_reg, tx_trunc_next;

  // Reflected CRC-32 over one byte, least-significant bit first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign pay_cnt_inc = pay_cnt_reg + 11'd1;

  // Next-state and next-output decode; every emitted byte is chosen here.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pay_cnt_next  = pay_cnt_reg;
    hdr_next      = hdr_reg;
    tx_valid_next = 1'b0;
    tx_data_next  = 8'h00;
    tx_done_next  = 1'b0;
    tx_trunc_next = 1'b0;
    crc_en        = 1'b0;
    crc_init      = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        // The pending payload byte is left with the source; only headers latch.
        if (in_valid) begin
          hdr_next      = {dest_mac, src_mac, ether_type};
          tx_valid_next = 1'b1;
          tx_data_next  = 8'h55;
          idx_next      = 8'd1;
          state_next    = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        tx_valid_next = 1'b1;
        tx_data_next  = 8'h55;
        if (idx_reg == 8'd6) begin
          idx_next   = 8'd0;
          state_next = S_SFD;
        end else begin
          idx_next = idx_reg + 8'd1;
        end
      end
      S_SFD: begin
        tx_valid_next = 1'b1;
        tx_data_next  = 8'hD5;
        crc_init      = 1'b1;
        idx_next      = 8'd0;
        state_next    = S_DEST;
      end
      S_DEST, S_SRC, S_TYPE: begin
        // Header bytes leave the top of a shift register, MSB byte first.
        tx_valid_next = 1'b1;
        tx_data_next  = hdr_reg[111:104];
        hdr_next      = {hdr_reg[103:0], 8'h00};
        crc_en        = 1'b1;
        idx_next      = idx_reg + 8'd1;
        if (state_reg == S_DEST && idx_reg == 8'd5) begin
          idx_next   = 8'd0;
          state_next = S_SRC;
        end else if (state_reg == S_SRC && idx_reg == 8'd5) begin
          idx_next   = 8'd0;
          state_next = S_TYPE;
        end else if (state_reg == S_TYPE && idx_reg == 8'd1) begin
          idx_next     = 8'd0;
          pay_cnt_next = 11'd0;
          state_next   = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        // in_ready is high in this state, so in_valid alone marks a transfer.
        if (in_valid) begin
          tx_valid_next = 1'b1;
          tx_data_next  = in_data;
          crc_en        = 1'b1;
          pay_cnt_next  = pay_cnt_inc;
          if (in_last || pay_cnt_inc == MAX_CNT) begin
            tx_trunc_next = ~in_last;
            idx_next      = 8'd0;
            state_next    = (pay_cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        tx_valid_next = 1'b1;
        tx_data_next  = 8'h00;
        crc_en        = 1'b1;
        pay_cnt_next  = pay_cnt_inc;
        if (pay_cnt_inc == MIN_CNT) begin
          idx_next   = 8'd0;
          state_next = S_FCS;
        end
      end
      S_FCS: begin
        // Complemented CRC, least-significant byte first; CRC is frozen here.
        tx_valid_next = 1'b1;
        case (idx_reg[1:0])
          2'd0: tx_data_next = ~crc_reg[7:0];
          2'd1: tx_data_next = ~crc_reg[15:8];
          2'd2: tx_data_next = ~crc_reg[23:16];
          2'd3: tx_data_next = ~crc_reg[31:24];
        endcase
        if (idx_reg == 8'd3) begin
          tx_done_next = 1'b1;
          idx_next     = 8'd0;
          state_next   = S_IFG;
        end else begin
          idx_next = idx_reg + 8'd1;
        end
      end
      S_IFG: begin
        if (idx_reg == IFG_LAST) begin
          idx_next   = 8'd0;
          state_next = S_IDLE;
        end else begin
          idx_next = idx_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = 8'd0;
      end
    endcase

    in_ready_next = (state_next == S_PAYLOAD);
    tx_busy_next  = (state_next != S_IDLE);
  end

  // CRC accumulator: seeded at SFD, advanced only on header/payload/pad bytes.
  always_comb begin
    crc_next = crc_reg;
    if (crc_init) begin
      crc_next = CRC_INIT;
    end else if (crc_en) begin
      crc_next = crc32_step(crc_reg, tx_data_next);
    end
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 8'd0;
      pay_cnt_reg  <= 11'd0;
      hdr_reg      <= '0;
      crc_reg      <= CRC_INIT;
      in_ready_reg <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
      tx_trunc_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      pay_cnt_reg  <= pay_cnt_next;
      hdr_reg      <= hdr_next;
      crc_reg      <= crc_next;
      in_ready_reg <= in_ready_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      tx_busy_reg  <= tx_busy_next;
      tx_done_reg  <= tx_done_next;
      tx_trunc_reg <= tx_trunc_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign tx_data_valid = tx_valid_reg;
  assign tx_data_out   = tx_data_reg;
  assign tx_busy       = tx_busy_reg;
  assign tx_done       = tx_done_reg;
  assign tx_trunc      = tx_trunc_reg;

endmodule

// File: tb/tb_ethernet_frame_tx.sv
// Self-checking bench for ethernet_frame_tx.
// Expected wire bytes are queued when a frame is offered and popped by a
// monitor as the framer emits them; frame length, CRC residue and gaps are
// checked on every tx_done.
module tb_ethernet_frame_tx;

  localparam int IFG = 12;

  typedef struct packed {
    logic [7:0] data;
    logic       done;
    logic       trunc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] ether_type;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        tx_data_valid;
  logic [7:0]  tx_data_out;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_trunc;

  logic [7:0]  pay_mem [0:1599];
  exp_t        exp_q[$];
  int          len_q[$];

  int          total = 0;
  int          bad = 0;

  // monitor state
  bit          in_frame = 0;
  bit          after_done = 0;
  bit          exact_gap = 0;
  int          frame_bytes = 0;
  int          mid_gaps = 0;
  int          idle_run = 0;
  int          last_mid_gaps = -1;
  logic [31:0] rx_crc = 32'hFFFFFFFF;
  logic [31:0] fcs_shift = 32'h0;
  logic [31:0] last_fcs = 32'h0;
  logic [31:0] fcs_ref = 32'h0;

  ethernet_frame_tx #(
    .MIN_PAYLOAD(46),
    .MAX_PAYLOAD(1500),
    .IFG_BYTES(IFG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dest_mac(dest_mac),
    .src_mac(src_mac),
    .ether_type(ether_type),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .tx_data_valid(tx_data_valid),
    .tx_data_out(tx_data_out),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_trunc(tx_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic void push_b(input logic [7:0] d, input logic dn, input logic tr);
    exp_t e;
    e.data  = d;
    e.done  = dn;
    e.trunc = tr;
    exp_q.push_back(e);
  endfunction

  // Reference frame: preamble, SFD, header, payload, pad, FCS (~crc, LSB first).
  function automatic void push_frame(input logic [47:0] d, input logic [47:0] s,
                                     input logic [15:0] t, input int start, input int n,
                                     input bit trunc);
    logic [31:0]  c;
    logic [111:0] h;
    logic [7:0]   b;
    logic [31:0]  f;
    for (int k = 0; k < 7; k++) push_b(8'h55, 1'b0, 1'b0);
    push_b(8'hD5, 1'b0, 1'b0);
    c = 32'hFFFFFFFF;
    h = {d, s, t};
    for (int k = 0; k < 14; k++) begin
      b = h[111:104];
      h = h << 8;
      c = crc_byte(c, b);
      push_b(b, 1'b0, 1'b0);
    end
    for (int k = 0; k < n; k++) begin
      b = pay_mem[start + k];
      c = crc_byte(c, b);
      push_b(b, 1'b0, trunc && (k == n - 1));
    end
    for (int k = n; k < 46; k++) begin
      c = crc_byte(c, 8'h00);
      push_b(8'h00, 1'b0, 1'b0);
    end
    f = ~c;
    for (int k = 0; k < 4; k++) begin
      push_b(f[7:0], k == 3, 1'b0);
      f = f >> 8;
    end
    len_q.push_back(8 + 14 + ((n < 46) ? 46 : n) + 4);
  endfunction

  task automatic check_reset(input string tag);
    total++;
    assert (in_ready === 1'b0) else begin bad++; $error("FAIL %s_in_ready got=%0b want=0", tag, in_ready); end
    total++;
    assert (tx_data_valid === 1'b0) else begin bad++; $error("FAIL %s_valid got=%0b want=0", tag, tx_data_valid); end
    total++;
    assert (tx_data_out === 8'h00) else begin bad++; $error("FAIL %s_data got=%0h want=00", tag, tx_data_out); end
    total++;
    assert (tx_busy === 1'b0) else begin bad++; $error("FAIL %s_busy got=%0b want=0", tag, tx_busy); end
    total++;
    assert (tx_done === 1'b0) else begin bad++; $error("FAIL %s_done got=%0b want=0", tag, tx_done); end
    total++;
    assert (tx_trunc === 1'b0) else begin bad++; $error("FAIL %s_trunc got=%0b want=0", tag, tx_trunc); end
  endtask

  // Hold the presented byte until a clock edge sees in_ready high.
  task automatic wait_xfer(input int idx);
    bit ok;
    int waited;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 400) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    total++;
    assert (ok === 1'b1) else begin bad++; $error("FAIL xfer_timeout byte=%0d got=%0b want=1", idx, ok); end
  endtask

  task automatic drive(input int start, input int n, input bit set_last,
                       input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = pay_mem[start + i];
      in_last  = set_last && (i == n - 1);
      wait_xfer(start + i);
    end
  endtask

  task automatic release_src();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() === 0) else begin bad++; $error("FAIL %s_drain left=%0d want=0", tag, exp_q.size()); end
    $display("frame %s: bytes=%0d fcs=%08h stall_gaps=%0d", tag, frame_bytes, last_fcs, last_mid_gaps);
  endtask

  // Output monitor: scoreboard pop, idle-output rules, per-frame length/residue/gap.
  initial begin
    exp_t e;
    int   exp_len;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame   = 1'b0;
        after_done = 1'b0;
        frame_bytes = 0;
        mid_gaps   = 0;
        idle_run   = 0;
      end else if (tx_data_valid) begin
        if (after_done) begin
          total++;
          if (exact_gap) begin
            assert (idle_run === IFG) else begin bad++; $error("FAIL ifg_exact got=%0d want=%0d", idle_run, IFG); end
          end else begin
            assert (idle_run >= IFG) else begin bad++; $error("FAIL ifg_min got=%0d want>=%0d", idle_run, IFG); end
          end
          after_done = 1'b0;
        end
        if (!in_frame) begin
          in_frame    = 1'b1;
          frame_bytes = 0;
          mid_gaps    = 0;
          rx_crc      = 32'hFFFFFFFF;
        end
        frame_bytes++;
        if (frame_bytes > 8) rx_crc = crc_byte(rx_crc, tx_data_out);
        fcs_shift = {tx_data_out, fcs_shift[31:8]};
        total++;
        assert (tx_busy === 1'b1) else begin bad++; $error("FAIL busy_in_frame got=%0b want=1", tx_busy); end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL extra_byte got=%02h want=none", tx_data_out);
        end else begin
          e = exp_q.pop_front();
          total++;
          assert (tx_data_out === e.data) else begin
            bad++; $error("FAIL byte%0d got=%02h want=%02h", frame_bytes, tx_data_out, e.data);
          end
          total++;
          assert ({tx_done, tx_trunc} === {e.done, e.trunc}) else begin
            bad++; $error("FAIL pulses%0d got=%b want=%b", frame_bytes, {tx_done, tx_trunc}, {e.done, e.trunc});
          end
        end
        if (tx_done) begin
          in_frame      = 1'b0;
          after_done    = 1'b1;
          idle_run      = 0;
          last_fcs      = fcs_shift;
          last_mid_gaps = mid_gaps;
          total++;
          assert (rx_crc === 32'hDEBB20E3) else begin bad++; $error("FAIL residue got=%08h want=debb20e3", rx_crc); end
          exp_len = (len_q.size() != 0) ? len_q.pop_front() : -1;
          total++;
          assert (frame_bytes === exp_len) else begin bad++; $error("FAIL frame_len got=%0d want=%0d", frame_bytes, exp_len); end
        end
      end else begin
        total++;
        assert ({tx_data_out, tx_done, tx_trunc} === 10'h0) else begin
          bad++; $error("FAIL idle_outputs got=%03h want=000", {tx_data_out, tx_done, tx_trunc});
        end
        if (in_frame) mid_gaps++;
        if (after_done) idle_run++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    dest_mac   = 48'h0;
    src_mac    = 48'h0;
    ether_type = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // T1: minimum frame, one payload byte padded to 46
    dest_mac   = 48'h0010A47BEA80;
    src_mac    = 48'h02005E100001;
    ether_type = 16'h0800;
    pay_mem[0] = 8'hAB;
    push_frame(dest_mac, src_mac, ether_type, 0, 1, 1'b0);
    drive(0, 1, 1'b1, -1, 0);
    release_src();
    drain("t1_min");

    // T2: "123456789" behind fixed headers
    dest_mac   = 48'hFFFFFFFFFFFF;
    src_mac    = 48'h123456789ABC;
    ether_type = 16'h88B5;
    for (int i = 0; i < 9; i++) pay_mem[i] = 8'(8'h31 + i);
    push_frame(dest_mac, src_mac, ether_type, 0, 9, 1'b0);
    drive(0, 9, 1'b1, -1, 0);
    release_src();
    drain("t2_crc");

    // T3: 60 bytes without and with a 3-cycle source pause at byte 20
    for (int i = 0; i < 60; i++) pay_mem[i] = 8'(i * 13 + 5);
    push_frame(dest_mac, src_mac, ether_type, 0, 60, 1'b0);
    drive(0, 60, 1'b1, -1, 0);
    release_src();
    drain("t3_nostall");
    fcs_ref = last_fcs;
    total++;
    assert (last_mid_gaps === 0) else begin bad++; $error("FAIL nostall_gaps got=%0d want=0", last_mid_gaps); end
    push_frame(dest_mac, src_mac, ether_type, 0, 60, 1'b0);
    drive(0, 60, 1'b1, 20, 3);
    release_src();
    drain("t3_stall");
    total++;
    assert (last_mid_gaps === 3) else begin bad++; $error("FAIL stall_gaps got=%0d want=3", last_mid_gaps); end
    total++;
    assert (last_fcs === fcs_ref) else begin bad++; $error("FAIL stall_fcs got=%08h want=%08h", last_fcs, fcs_ref); end

    // T4: 1600 bytes, no in_last within the first 1500; byte 1501 opens the next frame
    for (int i = 0; i < 1600; i++) pay_mem[i] = 8'(i ^ (i >> 3));
    exact_gap = 1'b1;
    push_frame(dest_mac, src_mac, ether_type, 0, 1500, 1'b1);
    push_frame(dest_mac, src_mac, ether_type, 1500, 100, 1'b0);
    drive(0, 1600, 1'b1, -1, 0);
    release_src();
    drain("t4_trunc");
    exact_gap = 1'b0;

    // T5: reset after 30 payload bytes, then a clean frame
    for (int i = 0; i < 60; i++) pay_mem[i] = 8'(8'hC0 ^ i);
    push_frame(dest_mac, src_mac, ether_type, 0, 60, 1'b0);
    drive(0, 30, 1'b0, -1, 0);
    release_src();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("t5_abort");
    exp_q.delete();
    len_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(dest_mac, src_mac, ether_type, 0, 5, 1'b0);
    drive(0, 5, 1'b1, -1, 0);
    release_src();
    drain("t5_after_reset");

    // T6: next frame's byte held valid through FCS and IFG
    for (int i = 0; i < 60; i++) pay_mem[i] = 8'(i * 7 + 1);
    exact_gap = 1'b1;
    push_frame(dest_mac, src_mac, ether_type, 0, 50, 1'b0);
    push_frame(dest_mac, src_mac, ether_type, 50, 10, 1'b0);
    drive(0, 50, 1'b1, -1, 0);
    in_valid = 1'b1;
    in_data  = pay_mem[50];
    in_last  = 1'b0;
    for (int k = 0; k < 4 + IFG + 1; k++) begin
      @(negedge clk);
      total++;
      assert (in_ready === 1'b0) else begin bad++; $error("FAIL b2b_in_ready cycle=%0d got=%0b want=0", k, in_ready); end
    end
    @(posedge clk);
    #1;
    drive(50, 10, 1'b1, -1, 0);
    release_src();
    drain("t6_b2b");
    exact_gap = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
